path_reader: RTL and testbench

PATH_READER -- requirements
Module: path_reader

---
 rtl/path_reader_pkg.sv | 29 ++
 rtl/path_reader.sv | 105 ++++++++++
 tb/tb_path_reader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/path_reader_pkg.sv
// Shared definitions for the path readout block: the location word width,
// the readout state encoding and the saturating length helper.
package path_reader_pkg;

  // Width of a maze location word {row, col}, each half LOC_W/2 bits
  localparam int LOC_W = 8;

  // Width of the emitted-location counter
  localparam int LEN_W = 8;

  // Largest value the emitted-location counter can hold
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  // Readout sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DONE   = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    EMIT   = 3'd4,
    FINISH = 3'd5
  } state_t;

  // Increment that sticks at the maximum instead of wrapping
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] value);
    return (value == LEN_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/path_reader.sv
// Path reader: after a search completes, tells the location stack it is done,
// gives it a cycle to reorder, then pops every stored location and presents
// each one downstream with a valid/ready handshake until the stack runs dry.
module path_reader
  import path_reader_pkg::*;
#(
  parameter int LOC_W = path_reader_pkg::LOC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             empStck,
  input  logic [LOC_W-1:0] stkLoc,
  output logic             stkDone,
  output logic             stkPop,
  output logic [LOC_W-1:0] pathLoc,
  output logic             pathValid,
  input  logic             pathReady,
  output logic [LEN_W-1:0] pathLen,
  output logic             busy,
  output logic             finished
);

  state_t             state_reg;
  logic [LOC_W-1:0]   loc_reg;
  logic               valid_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               done_reg;
  logic               fin_reg;
  logic               busy_reg;

  // Sequencer plus all registered outputs; reset clears everything at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      loc_reg   <= '0;
      valid_reg <= 1'b0;
      len_reg   <= '0;
      done_reg  <= 1'b0;
      fin_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      // Pulse outputs default low and are raised only on entry to their state
      done_reg <= 1'b0;
      fin_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= DONE;
            len_reg   <= '0;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= SETTLE;
        end
        SETTLE: begin
          // The stack reorders during this cycle; its flags are trusted next
          state_reg <= CHECK;
        end
        CHECK: begin
          if (empStck) begin
            state_reg <= FINISH;
            fin_reg   <= 1'b1;
          end else begin
            // The pop strobe is high this cycle, so the current top is taken now
            loc_reg   <= stkLoc;
            valid_reg <= 1'b1;
            state_reg <= EMIT;
          end
        end
        EMIT: begin
          if (pathReady) begin
            valid_reg <= 1'b0;
            len_reg   <= sat_inc(len_reg);
            state_reg <= CHECK;
          end
        end
        FINISH: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // The pop must coincide with the cycle whose top-of-stack is captured, and
  // emptiness is only known once CHECK is reached, so it is decoded from the
  // registered state rather than registered itself.
  assign stkPop = (state_reg == CHECK) && !empStck;

  assign stkDone   = done_reg;
  assign pathLoc   = loc_reg;
  assign pathValid = valid_reg;
  assign pathLen   = len_reg;
  assign busy      = busy_reg;
  assign finished  = fin_reg;

endmodule

// File: tb/tb_path_reader.sv
// Self-checking bench for path_reader: a queue-based stack model feeds the
// design, a negedge monitor records handshakes, and each readout is compared
// against the list of locations that was loaded into the stack.
module tb_path_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       emp_stck = 1'b1;
  logic [7:0] stk_loc = 8'h00;
  logic       stk_done;
  logic       stk_pop;
  logic [7:0] path_loc;
  logic       path_valid;
  logic       path_ready = 1'b0;
  logic [7:0] path_len;
  logic       busy;
  logic       finished;

  int total = 0;
  int bad = 0;

  // Stack contents (front = top) and expected pop order
  logic [7:0] stk_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] acc_q[$];

  int ready_mode = 0;  // 0: hold low, 1: hold high, 2: random
  int cyc = 0;
  int done_cnt = 0, pop_cnt = 0, fin_cnt = 0, viol_cnt = 0, valid_seen = 0;
  int done_cyc = 0, fin_cyc = 0;
  bit prev_pop = 0, prev_done = 0;

  path_reader #(.LOC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .empStck   (emp_stck),
    .stkLoc    (stk_loc),
    .stkDone   (stk_done),
    .stkPop    (stk_pop),
    .pathLoc   (path_loc),
    .pathValid (path_valid),
    .pathReady (path_ready),
    .pathLen   (path_len),
    .busy      (busy),
    .finished  (finished)
  );

  always #5 clk = ~clk;

  // Behavioural stack: pops on a strobed edge, presents the new top afterwards
  always @(posedge clk) begin
    if (stk_pop && stk_q.size() > 0) void'(stk_q.pop_front());
    emp_stck <= (stk_q.size() == 0);
    stk_loc  <= (stk_q.size() > 0) ? stk_q[0] : 8'h00;
  end

  // Downstream ready driver, changes just after each rising edge
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       path_ready = 1'b0;
      1:       path_ready = 1'b1;
      default: path_ready = ($urandom_range(0, 9) < 6);
    endcase
  end

  // Monitor: everything observed mid-cycle describes the coming edge
  always @(negedge clk) begin
    cyc++;
    if (stk_done) begin done_cnt++; done_cyc = cyc; end
    if (stk_pop) pop_cnt++;
    if (stk_pop && (stk_done || prev_pop)) viol_cnt++;
    if (stk_done && prev_done) viol_cnt++;
    prev_pop  = stk_pop;
    prev_done = stk_done;
    if (path_valid) valid_seen++;
    if (path_valid && path_ready) acc_q.push_back(path_loc);
    if (finished) begin fin_cnt++; fin_cyc = cyc; end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    done_cnt = 0; pop_cnt = 0; fin_cnt = 0; viol_cnt = 0; valid_seen = 0;
    acc_q.delete();
  endtask

  // Copy the expected list into the stack model while the design is idle
  task automatic load_stack();
    @(negedge clk);
    stk_q.delete();
    foreach (exp_q[i]) stk_q.push_back(exp_q[i]);
  endtask

  task automatic start_pulse();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_finish(input string tag, input int limit);
    int i = 0;
    while (fin_cnt == 0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    check_val({tag, "_finish_seen"}, fin_cnt, 1);
    @(negedge clk);
  endtask

  // Reference: every loaded location comes out once in pop order, the
  // length counter is the emitted count clipped at 255
  task automatic check_result(input string tag);
    int n = exp_q.size();
    int exp_len = (n > 255) ? 255 : n;
    int m = (acc_q.size() < n) ? acc_q.size() : n;
    check_val({tag, "_emitted"}, acc_q.size(), n);
    for (int i = 0; i < m; i++) check_val({tag, "_loc"}, acc_q[i], exp_q[i]);
    check_val({tag, "_len"}, path_len, exp_len);
    check_val({tag, "_pops"}, pop_cnt, n);
    check_val({tag, "_done_pulses"}, done_cnt, 1);
    check_val({tag, "_strobe_rules"}, viol_cnt, 0);
    check_val({tag, "_idle_busy"}, busy, 0);
    $display("case %s: n=%0d emitted=%0d len=%0d pops=%0d", tag, n, acc_q.size(), path_len, pop_cnt);
  endtask

  task automatic run_case(input string tag);
    load_stack();
    clear_mon();
    start_pulse();
    wait_finish(tag, 40 * exp_q.size() + 40);
    check_result(tag);
  endtask

  initial begin
    // Reset values while reset is held across clock edges
    repeat (2) @(negedge clk);
    check_val("rst_done", stk_done, 0);
    check_val("rst_pop", stk_pop, 0);
    check_val("rst_valid", path_valid, 0);
    check_val("rst_loc", path_loc, 0);
    check_val("rst_len", path_len, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_finished", finished, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed three-entry readout at full throughput
    exp_q = {8'h40, 8'h01, 8'ha9};
    ready_mode = 1;
    run_case("three");

    // Empty stack: finished three cycles after the done pulse
    exp_q.delete();
    run_case("empty");
    check_val("empty_fin_delay", fin_cyc - done_cyc, 3);
    check_val("empty_no_valid", valid_seen, 0);

    // Downstream stall with the first location held
    exp_q = {8'h40, 8'h77};
    ready_mode = 0;
    load_stack();
    clear_mon();
    start_pulse();
    for (int i = 0; i < 50 && !path_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_val("stall_loc", path_loc, 8'h40);
      check_val("stall_valid", path_valid, 1);
      check_val("stall_pops", pop_cnt, 1);
      @(negedge clk);
    end
    ready_mode = 1;
    wait_finish("stall", 100);
    check_result("stall");

    // Second start while busy must be ignored
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    ready_mode = 2;
    load_stack();
    clear_mon();
    start_pulse();
    repeat (3) @(negedge clk);
    check_val("restart_busy", busy, 1);
    start_pulse();
    wait_finish("restart", 400);
    check_result("restart");

    // Randomised lengths, contents and downstream backpressure
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(0, 20);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom_range(0, 255)));
      ready_mode = 2;
      run_case($sformatf("rand%0d", r));
    end

    // Length counter saturation with more locations than it can count
    exp_q.delete();
    for (int i = 0; i < 300; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    ready_mode = 1;
    run_case("sat300");

    // Asynchronous reset during EMIT after some locations were emitted
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'($urandom_range(1, 255)));
    ready_mode = 1;
    load_stack();
    clear_mon();
    start_pulse();
    for (int i = 0; i < 100 && !(path_valid && path_len >= 2); i++) @(negedge clk);
    check_val("mid_valid_before", path_valid, 1);
    #1 rst = 1'b1;
    #1;
    check_val("mid_valid", path_valid, 0);
    check_val("mid_busy", busy, 0);
    check_val("mid_len", path_len, 0);
    check_val("mid_loc", path_loc, 0);
    check_val("mid_pop", stk_pop, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    repeat (10) @(negedge clk);
    check_val("post_rst_busy", busy, 0);
    check_val("post_rst_pops", pop_cnt, 0);
    check_val("post_rst_done", done_cnt, 0);
    $display("case midreset: pops_after=%0d busy=%0d", pop_cnt, busy);
    exp_q.delete();
    load_stack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
